// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / multicycle-FPU stall and taken-branch flush sequencer for the 5-stage core
// Ports: clk/rst (async, active-low); ID source regs and use flags; EX rd, load, reg-write,
// multicycle-FPU and branch-taken flags in; stall/bubble/flush enables, fpu_busy and FSM state out;
// stall_cycles/flush_count performance counters, built only when HAZARD_PERF_EN is defined (else tied to 0).
module hazard_control_unit #(
  parameter int LOAD_STALL_CYC = 2,
  parameter int FPU_LAT = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic        ex_fpu_mc,
  input  logic        ex_branch_taken,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        stall_ex,
  output logic        bubble_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        fpu_busy,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] FPU_WAIT = 2'd2;
  localparam bit FPU_STALL = FPU_LAT > 1;
  localparam bit FPU_HOLD = FPU_LAT > 2;
  localparam bit LOAD_HOLD = LOAD_STALL_CYC > 1;
  // the trigger cycle in RUN is the first stalled cycle, so the wait states cover the remainder
  localparam logic [CNT_W-1:0] FPU_INIT = CNT_W'(FPU_HOLD ? FPU_LAT - 3 : 0);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_HOLD ? LOAD_STALL_CYC - 2 : 0);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic load_use, run, fpu_go, lu_go, ls, fw, hold;
  always_comb begin
    load_use = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    run = state_q == RUN;
    ls = state_q == LOAD_STALL;
    fw = state_q == FPU_WAIT;
    fpu_go = run & ~ex_branch_taken & ex_fpu_mc & FPU_STALL;
    lu_go = run & ~ex_branch_taken & ~(ex_fpu_mc & FPU_STALL) & load_use;
    hold = (ls | fw) & (cnt != '0);
    state_d = (fpu_go & FPU_HOLD) ? FPU_WAIT : (lu_go & LOAD_HOLD) ? LOAD_STALL : hold ? state_q : RUN;
    cnt_d = fpu_go ? FPU_INIT : lu_go ? LOAD_INIT : hold ? cnt - CNT_W'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RUN;
      cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt <= cnt_d;
    end
  assign stall_if = rst & (fpu_go | lu_go | ls | fw);
  assign stall_id = stall_if;
  assign bubble_ex = rst & (lu_go | ls);
  assign stall_ex = rst & (fpu_go | fw);
  assign bubble_mem = stall_ex;
  assign fpu_busy = stall_ex;
  assign flush_if_id = rst & run & ex_branch_taken;
  assign flush_id_ex = flush_if_id;
  assign state = state_q & {2{rst}};
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall_if);
      flush_count <= flush_count + 16'(flush_if_id);
    end
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule
